// File: rtl/conv_pkg.sv
// conv_pkg: shared sequencer state encoding and derived address-width helpers
// for the convolution datapath blocks.
package conv_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    function automatic int ofm_w(input int ifm_w, input int k);
        return ifm_w - k + 1;
    endfunction

    function automatic int ia_w(input int ifm_w);
        return $clog2(ifm_w * ifm_w);
    endfunction

    function automatic int wa_w(input int k);
        return $clog2(k * k);
    endfunction

    function automatic int oa_w(input int ifm_w, input int k);
        return $clog2(ofm_w(ifm_w, k) * ofm_w(ifm_w, k));
    endfunction

endpackage

// File: rtl/conv_dly_pipe.sv
// conv_dly_pipe: shift register of {valid, first, last, oaddr} words; exposes
// {valid, first} at TAP_A, {last, oaddr} at TAP_B, and whether any tap is still in flight.
module conv_dly_pipe #(
    parameter int W     = 8,
    parameter int TAP_A = 1,
    parameter int TAP_B = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] d_i,
    output logic [1:0]   a_o,
    output logic [W-3:0] b_o,
    output logic         busy_o
);

    logic [W-1:0] sr_q [1:TAP_B];

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 1; i <= TAP_B; i++) sr_q[i] <= '0;
        end else begin
            sr_q[1] <= d_i;
            for (int i = 2; i <= TAP_B; i++) sr_q[i] <= sr_q[i-1];
        end
    end

    // The final stage is excluded: it empties on the same edge the FSM leaves DRAIN.
    always_comb begin
        busy_o = 1'b0;
        for (int i = 1; i < TAP_B; i++) busy_o = busy_o | sr_q[i][W-1];
    end

    assign a_o = sr_q[TAP_A][W-1 -: 2];
    assign b_o = sr_q[TAP_B][W-3:0];

endmodule

// File: rtl/conv_seq_ctrl.sv
// conv_seq_ctrl: walks every output pixel and kernel tap of one stride-1, unpadded
// convolution pass, issuing buffer reads, MAC strobes and ofmap writes.
module conv_seq_ctrl
    import conv_pkg::*;
#(
    parameter  int IFM_W   = 6,
    parameter  int K       = 3,
    parameter  int RD_LAT  = 1,
    parameter  int MAC_LAT = 1,
    localparam int OFM_W   = ofm_w(IFM_W, K),
    localparam int IA_W    = ia_w(IFM_W),
    localparam int WA_W    = wa_w(K),
    localparam int OA_W    = oa_w(IFM_W, K)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            hold,
    output logic [IA_W-1:0] ifmd_rd_addr,
    output logic [WA_W-1:0] wgt_rd_addr,
    output logic            rd_en,
    output logic            mac_clr,
    output logic            mac_en,
    output logic            ofmd_wr_en,
    output logic [OA_W-1:0] ofmd_wr_addr,
    output logic            busy,
    output logic            done
);

    localparam logic [IA_W-1:0] KM1 = IA_W'(K - 1);
    localparam logic [IA_W-1:0] OM1 = IA_W'(OFM_W - 1);
    localparam logic [IA_W-1:0] ONE = IA_W'(1);
    localparam int PW = OA_W + 3;

    state_t          state_q, state_d;
    logic [IA_W-1:0] orow_q, ocol_q, kr_q, kc_q, orow_d, ocol_d, kr_d, kc_d;
    logic [IA_W-1:0] ia_q;
    logic [WA_W-1:0] wa_q;
    logic [OA_W-1:0] oa_q;
    logic            kc_w, kr_w, oc_w, or_w, last_tap, pipe_busy;
    logic [PW-1:0]   pin;
    logic [1:0]      pa;
    logic [OA_W:0]   pb;

    always_comb begin
        kc_w     = kc_q == KM1;
        kr_w     = kr_q == KM1;
        oc_w     = ocol_q == OM1;
        or_w     = orow_q == OM1;
        rd_en    = state_q == RUN && !hold;
        last_tap = kc_w && kr_w && oc_w && or_w;
        kc_d     = rd_en ? (kc_w ? '0 : kc_q + ONE) : kc_q;
        kr_d     = rd_en && kc_w ? (kr_w ? '0 : kr_q + ONE) : kr_q;
        ocol_d   = rd_en && kc_w && kr_w ? (oc_w ? '0 : ocol_q + ONE) : ocol_q;
        orow_d   = rd_en && kc_w && kr_w && oc_w ? (or_w ? '0 : orow_q + ONE) : orow_q;
        state_d  = state_q;
        case (state_q)
            IDLE:    if (start) state_d = RUN;
            RUN:     if (rd_en && last_tap) state_d = DRAIN;
            DRAIN:   if (!pipe_busy) state_d = DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            orow_q  <= '0;
            ocol_q  <= '0;
            kr_q    <= '0;
            kc_q    <= '0;
            ia_q    <= '0;
            wa_q    <= '0;
            oa_q    <= '0;
        end else begin
            state_q <= state_d;
            orow_q  <= orow_d;
            ocol_q  <= ocol_d;
            kr_q    <= kr_d;
            kc_q    <= kc_d;
            ia_q    <= IA_W'((int'(orow_d) + int'(kr_d)) * IFM_W + int'(ocol_d) + int'(kc_d));
            wa_q    <= WA_W'(int'(kr_d) * K + int'(kc_d));
            if (ofmd_wr_en) oa_q <= pb[OA_W-1:0];
        end
    end

    // "last" is only ever set alongside valid, so it doubles as the write strobe.
    assign pin = {rd_en, rd_en && kr_q == '0 && kc_q == '0, rd_en && kc_w && kr_w,
                  OA_W'(int'(orow_q) * OFM_W + int'(ocol_q))};

    conv_dly_pipe #(.W(PW), .TAP_A(RD_LAT), .TAP_B(RD_LAT + MAC_LAT)) u_pipe (
        .clk    (clk),
        .rst    (rst),
        .d_i    (pin),
        .a_o    (pa),
        .b_o    (pb),
        .busy_o (pipe_busy)
    );

    assign ifmd_rd_addr = ia_q;
    assign wgt_rd_addr  = wa_q;
    assign mac_en       = pa[1];
    assign mac_clr      = pa[0];
    assign ofmd_wr_en   = pb[OA_W];
    assign ofmd_wr_addr = ofmd_wr_en ? pb[OA_W-1:0] : oa_q;
    assign busy         = state_q == RUN || state_q == DRAIN;
    assign done         = state_q == DONE;

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// tb_conv_seq_ctrl: scoreboard bench for conv_seq_ctrl; stimulus queues expected
// reads/MAC strobes/writes/done, a negedge monitor pops and compares them.
module tb_conv_seq_ctrl;

    logic       clk = 0, rst = 0, start = 0, hold = 0;
    logic       rd_en, mac_clr, mac_en, wr_en, busy, done;
    logic [5:0] ia;
    logic [3:0] wa, oa;
    logic       rd_en2, mac_clr2, mac_en2, wr_en2, busy2, done2;
    logic [5:0] ia2;
    logic [3:0] wa2, oa2;

    conv_seq_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .hold(hold),
        .ifmd_rd_addr(ia), .wgt_rd_addr(wa), .rd_en(rd_en), .mac_clr(mac_clr), .mac_en(mac_en),
        .ofmd_wr_en(wr_en), .ofmd_wr_addr(oa), .busy(busy), .done(done)
    );

    conv_seq_ctrl #(.RD_LAT(2), .MAC_LAT(3)) dut2 (
        .clk(clk), .rst(rst), .start(start), .hold(hold),
        .ifmd_rd_addr(ia2), .wgt_rd_addr(wa2), .rd_en(rd_en2), .mac_clr(mac_clr2), .mac_en(mac_en2),
        .ofmd_wr_en(wr_en2), .ofmd_wr_addr(oa2), .busy(busy2), .done(done2)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {int c; int a; int b;} ev_t;
    ev_t rd_q[$], mac_q[$], wr_q[$];
    int  done_q[$], ia_log[$], wr_log[$];
    int  checks = 0, failures = 0;
    int  last_done = -1, t_mac2 = -1, t_wr2 = -1, t_done2 = -1;
    bit  arm2 = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", nm, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        ev_t e;
        if (rd_en) begin
            ia_log.push_back(int'(ia));
            chk("rd_pending", int'(rd_q.size() > 0), 1);
            if (rd_q.size() > 0) begin
                e = rd_q.pop_front();
                chk("rd_cycle", cyc, e.c);
                chk("rd_ifmd_addr", ia, e.a);
                chk("rd_wgt_addr", wa, e.b);
            end
        end
        chk("mac_clr_without_en", int'(mac_clr && !mac_en), 0);
        if (mac_en) begin
            chk("mac_pending", int'(mac_q.size() > 0), 1);
            if (mac_q.size() > 0) begin
                e = mac_q.pop_front();
                chk("mac_cycle", cyc, e.c);
                chk("mac_clr", mac_clr, e.a);
            end
        end
        if (wr_en) begin
            wr_log.push_back(cyc);
            chk("wr_pending", int'(wr_q.size() > 0), 1);
            if (wr_q.size() > 0) begin
                e = wr_q.pop_front();
                chk("wr_cycle", cyc, e.c);
                chk("wr_addr", oa, e.a);
            end
        end
        if (done) begin
            last_done = cyc;
            chk("done_pending", int'(done_q.size() > 0), 1);
            if (done_q.size() > 0) chk("done_cycle", cyc, done_q.pop_front());
        end
        if (arm2) begin
            if (mac_en2 && t_mac2 < 0) t_mac2 = cyc;
            if (wr_en2 && t_wr2 < 0) t_wr2 = cyc;
            if (done2 && t_done2 < 0) t_done2 = cyc;
        end
    end

    // Expected timeline: taps issue back to back except during hold [hs,he]; nothing after cut.
    task automatic push_pass(input int b, input int hs, input int he, input int cut);
        int c  = b + 1;
        int lc = 0;
        for (int orow = 0; orow < 4; orow++)
            for (int ocol = 0; ocol < 4; ocol++)
                for (int kr = 0; kr < 3; kr++)
                    for (int kc = 0; kc < 3; kc++) begin
                        while (c >= hs && c <= he) c++;
                        if (c <= cut) rd_q.push_back('{c, (orow + kr) * 6 + ocol + kc, kr * 3 + kc});
                        if (c + 1 <= cut) mac_q.push_back('{c + 1, (kr == 0 && kc == 0) ? 1 : 0, 0});
                        if (kr == 2 && kc == 2 && c + 2 <= cut) wr_q.push_back('{c + 2, orow * 4 + ocol, 0});
                        lc = c;
                        c++;
                    end
        if (lc + 3 <= cut) done_q.push_back(lc + 3);
    endtask

    task automatic to_cyc(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_start(output int b);
        @(posedge clk);
        #1;
        start = 1;
        b = cyc;
        @(posedge clk);
        #1;
        start = 0;
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_rd_en"}, rd_en, 0);
        chk({tag, "_ifmd_addr"}, ia, 0);
        chk({tag, "_wgt_addr"}, wa, 0);
        chk({tag, "_mac_en"}, mac_en, 0);
        chk({tag, "_mac_clr"}, mac_clr, 0);
        chk({tag, "_wr_en"}, wr_en, 0);
        chk({tag, "_wr_addr"}, oa, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
    endtask

    task automatic end_pass();
        chk("rd_left", rd_q.size(), 0);
        chk("mac_left", mac_q.size(), 0);
        chk("wr_left", wr_q.size(), 0);
        chk("done_left", done_q.size(), 0);
    endtask

    int w0[9] = '{0, 1, 2, 6, 7, 8, 12, 13, 14};
    int w1[9] = '{1, 2, 3, 7, 8, 9, 13, 14, 15};

    initial begin
        int b;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_idle_outputs("in_reset");
        to_cyc(cyc + 1);
        rst = 1;
        @(negedge clk);
        chk_idle_outputs("after_reset");

        // Full pass, plus the slower-latency instance in parallel.
        ia_log.delete();
        wr_log.delete();
        arm2 = 1;
        do_start(b);
        push_pass(b, -1, -1, 1 << 30);
        to_cyc(b + 15);
        @(negedge clk);
        chk("wr_addr_holds_0", oa, 0);
        to_cyc(b + 25);
        @(negedge clk);
        chk("wr_addr_holds_1", oa, 1);
        to_cyc(b + 146);
        @(negedge clk);
        chk("busy_146", busy, 1);
        chk("done_146", done, 0);
        to_cyc(b + 147);
        @(negedge clk);
        chk("busy_147", busy, 0);
        chk("done_147", done, 1);
        to_cyc(b + 148);
        @(negedge clk);
        chk("done_148", done, 0);
        to_cyc(b + 160);
        arm2 = 0;
        chk("rd_count", ia_log.size(), 144);
        if (ia_log.size() >= 144) begin
            for (int i = 0; i < 9; i++) chk("win0_tap", ia_log[i], w0[i]);
            for (int i = 0; i < 9; i++) chk("win1_tap", ia_log[9 + i], w1[i]);
            chk("win15_first", ia_log[135], 21);
            chk("win15_last", ia_log[143], 35);
        end
        chk("wr_count", wr_log.size(), 16);
        if (wr_log.size() == 16) begin
            chk("first_wr_cycle", wr_log[0] - b, 11);
            chk("last_wr_cycle", wr_log[15] - b, 146);
        end
        chk("sweep_first_mac_en", t_mac2 - b, 3);
        chk("sweep_first_wr", t_wr2 - b, 14);
        chk("sweep_done", t_done2 - b, 150);
        end_pass();

        // Hold over cycles 50..52.
        wr_log.delete();
        do_start(b);
        push_pass(b, b + 50, b + 52, 1 << 30);
        to_cyc(b + 50);
        hold = 1;
        @(negedge clk);
        chk("hold50_rd_en", rd_en, 0);
        chk("hold50_ifmd", ia, 14);
        to_cyc(b + 52);
        @(negedge clk);
        chk("hold52_rd_en", rd_en, 0);
        chk("hold52_ifmd", ia, 14);
        to_cyc(b + 53);
        hold = 0;
        @(negedge clk);
        chk("resume_rd_en", rd_en, 1);
        chk("resume_ifmd", ia, 14);
        to_cyc(b + 160);
        chk("hold_wr_count", wr_log.size(), 16);
        if (wr_log.size() == 16) chk("hold_last_wr", wr_log[15] - b, 149);
        chk("hold_done", last_done - b, 150);
        end_pass();

        // Starts during RUN and DRAIN are ignored; the one in IDLE restarts.
        do_start(b);
        push_pass(b, -1, -1, 1 << 30);
        to_cyc(b + 20);
        start = 1;
        to_cyc(b + 21);
        start = 0;
        to_cyc(b + 146);
        start = 1;
        to_cyc(b + 147);
        start = 0;
        to_cyc(b + 148);
        start = 1;
        push_pass(b + 148, -1, -1, 1 << 30);
        to_cyc(b + 149);
        start = 0;
        @(negedge clk);
        chk("restart_rd_en", rd_en, 1);
        chk("restart_ifmd", ia, 0);
        to_cyc(b + 310);
        end_pass();

        // Reset mid-pass at cycle 60.
        do_start(b);
        push_pass(b, -1, -1, b + 60);
        to_cyc(b + 60);
        rst = 0;
        to_cyc(b + 61);
        rst = 1;
        @(negedge clk);
        chk_idle_outputs("abort");
        to_cyc(b + 100);
        end_pass();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
